// File: rtl/philo_log2_frac_if.sv
// Handshake bundle for the log2 fraction unit.
//   in_valid/in_ready/in_data/in_tag         : operand side (master drives valid/data/tag)
//   out_valid/out_ready/out_data/out_tag/out_err : result side (master drives ready)
// The master modport belongs to the producer/consumer around the unit,
// the slave modport to the unit itself.
interface philo_log2_frac_if #(
  parameter int MAN_WIDTH = 16,
  parameter int OUT_WIDTH = 7,
  parameter int TAG_WIDTH = 9
);
  logic                 in_valid;
  logic                 in_ready;
  logic [MAN_WIDTH-1:0] in_data;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 out_err;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/philo_log2_frac.sv
// Iterative log2 fraction unit (repeated squaring) for the bfloat16 FLOG path.
// Takes a normalised mantissa 1.f in [1,2) and produces frac(log2(1.f)),
// one result bit per cycle, MSB first.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : philo_log2_frac_if.slave
//           in_valid/in_ready/in_data/in_tag  - operand handshake (ready only in IDLE)
//           out_valid/out_ready               - result handshake, valid held until accepted
//           out_data                          - log2 fraction 0.b[OUT_WIDTH-1]..b[0]
//           out_tag                           - sideband returned unchanged
//           out_err                           - operand integer bit was 0
module philo_log2_frac #(
  parameter int MAN_WIDTH  = 16,
  parameter int OUT_WIDTH  = 7,
  parameter int ROUND      = 0,
  parameter int EARLY_EXIT = 1,
  parameter int TAG_WIDTH  = 9
) (
  input  logic clk,
  input  logic rst_n,
  philo_log2_frac_if.slave bus
);

  localparam int N  = OUT_WIDTH + ROUND;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [MAN_WIDTH-1:0] ONE = {1'b1, {(MAN_WIDTH-1){1'b0}}};

  logic [1:0]             state;
  logic [MAN_WIDTH-1:0]   man;
  logic [CW-1:0]          count;
  logic [N-1:0]           res;
  logic                   out_valid_q;
  logic [OUT_WIDTH-1:0]   out_data_q;
  logic [TAG_WIDTH-1:0]   out_tag_q;
  logic                   out_err_q;

  logic [2*MAN_WIDTH-1:0] sq;
  logic                   bit_now;
  logic [MAN_WIDTH-1:0]   man_next;
  logic [N-1:0]           res_next;

  // With ROUND=1 the LSB of the raw result is a guard bit; an all-ones
  // upper part is left alone so the fraction never wraps to zero.
  function automatic logic [OUT_WIDTH-1:0] round_sat(input logic [N-1:0] raw);
    logic [OUT_WIDTH-1:0] upper;
    logic                 guard;
    upper = raw[N-1 -: OUT_WIDTH];
    guard = (ROUND != 0) ? raw[0] : 1'b0;
    if (&upper) return upper;
    return upper + OUT_WIDTH'(guard);
  endfunction

  // Squaring a Q1.x value gives Q2.x: if the square reached 2.0 the result
  // bit is 1 and the mantissa is halved back into [1,2) by taking the top half.
  assign sq       = man * man;
  assign bit_now  = sq[2*MAN_WIDTH-1];
  assign man_next = bit_now ? sq[2*MAN_WIDTH-1:MAN_WIDTH] : sq[2*MAN_WIDTH-2:MAN_WIDTH-1];

  always_comb begin
    res_next        = res;
    res_next[count] = bit_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      man         <= '0;
      count       <= '0;
      res         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            man       <= bus.in_data;
            out_tag_q <= bus.in_tag;
            res       <= '0;
            count     <= CW'(N - 1);
            if (!bus.in_data[MAN_WIDTH-1]) begin
              out_err_q   <= 1'b1;
              out_data_q  <= '0;
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end else begin
              out_err_q <= 1'b0;
              state     <= S_EVAL;
            end
          end
        end
        S_EVAL: begin
          // Once the mantissa is exactly 1.0 every further square is 1.0,
          // so the remaining (already cleared) bits are all zero.
          if ((EARLY_EXIT != 0) && (man == ONE)) begin
            out_data_q  <= round_sat(res);
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end else begin
            res <= res_next;
            man <= man_next;
            if (count == '0) begin
              out_data_q  <= round_sat(res_next);
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end else begin
              count <= count - 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_err   = out_err_q;

endmodule
